// File: rtl/register_file4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | register_file4_pkg : shared sizes, FSM encoding and staging-tag layout   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package register_file4_pkg;

  localparam int ENTRIES  = 4;
  localparam int ADDRBITS = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Leading fields of the staging record {valid, address, data}.
  typedef struct packed {
    logic                valid;
    logic [ADDRBITS-1:0] addr;
  } stage_tag_t;

endpackage
`default_nettype wire

// File: rtl/basicmux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | basicmux : single-bit 2:1 multiplexer                                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module basicmux (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule
`default_nettype wire

// File: rtl/decoder2to4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decoder2to4 : enable-gated 2-to-4 one-hot decoder                        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module decoder2to4 (
  input  logic       i_en,
  input  logic [1:0] i_addr,
  output logic [3:0] o_onehot
);

  assign o_onehot = i_en ? (4'b0001 << i_addr) : 4'b0000;

endmodule
`default_nettype wire

// File: rtl/register_file4_staged_read_mux4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | read_mux4 : 4:1 read mux, two-level basicmux tree per data bit           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module read_mux4 #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] i_d0,
  input  logic [DATAWIDTH-1:0] i_d1,
  input  logic [DATAWIDTH-1:0] i_d2,
  input  logic [DATAWIDTH-1:0] i_d3,
  input  logic [1:0]           i_sel,
  output logic [DATAWIDTH-1:0] o_data
);

  genvar b;
  generate
    for (b = 0; b < DATAWIDTH; b++) begin : g_bit
      logic w_lo;
      logic w_hi;
      basicmux u_lo  (.i_a(i_d0[b]), .i_b(i_d1[b]), .i_sel(i_sel[0]), .o_y(w_lo));
      basicmux u_hi  (.i_a(i_d2[b]), .i_b(i_d3[b]), .i_sel(i_sel[0]), .o_y(w_hi));
      basicmux u_out (.i_a(w_lo),    .i_b(w_hi),    .i_sel(i_sel[1]), .o_y(o_data[b]));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/register_file4_staged.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | register_file4_staged : 4-entry regfile, staged writes, 2 registered     |
// | read ports, clear sweep. Option macro: REGFILE_BYPASS_EN. Rev 1.0        |
// +--------------------------------------------------------------------------+
module register_file4_staged
  import register_file4_pkg::*;
#(
  parameter int                   DATAWIDTH   = 8,
  parameter logic [DATAWIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_write_valid,
  output logic                 o_write_ready,
  input  logic [ADDRBITS-1:0]  i_write_address,
  input  logic [DATAWIDTH-1:0] i_write_data,
  input  logic                 i_clear_request,
  output logic                 o_clear_busy,
  input  logic [ADDRBITS-1:0]  i_read_address_a,
  output logic [DATAWIDTH-1:0] o_read_data_a,
  input  logic [ADDRBITS-1:0]  i_read_address_b,
  output logic [DATAWIDTH-1:0] o_read_data_b
);

  typedef struct packed {
    stage_tag_t           tag;
    logic [DATAWIDTH-1:0] data;
  } stage_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ADDRBITS-1:0]  r_cnt;
  logic [ADDRBITS-1:0]  w_cnt_next;
  stage_t               r_stage;
  logic [DATAWIDTH-1:0] r_mem [ENTRIES];
  logic [ENTRIES-1:0]   w_we;
  logic                 w_accept;
  logic [DATAWIDTH-1:0] w_arr_a;
  logic [DATAWIDTH-1:0] w_arr_b;
  logic                 w_fwd_a;
  logic                 w_fwd_b;
  logic [DATAWIDTH-1:0] r_rd_a;
  logic [DATAWIDTH-1:0] r_rd_b;

  assign o_write_ready = (r_state == ST_IDLE) && !i_clear_request;
  assign w_accept      = i_write_valid && o_write_ready;
  assign o_clear_busy  = (r_state == ST_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_clear_request) begin
          w_state_next = ST_CLEAR;
          w_cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == ADDRBITS'(ENTRIES - 1)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage.tag.valid <= w_accept;
      if (w_accept) begin
        r_stage.tag.addr <= i_write_address;
        r_stage.data     <= i_write_data;
      end
    end
  end

  decoder2to4 u_dec (
    .i_en     (r_stage.tag.valid),
    .i_addr   (r_stage.tag.addr),
    .o_onehot (w_we)
  );

  // Staging is always empty while clearing, so commit and sweep never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i] <= RESET_VALUE;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_we[i]) begin
          r_mem[i] <= r_stage.data;
        end else if ((r_state == ST_CLEAR) && (r_cnt == ADDRBITS'(i))) begin
          r_mem[i] <= RESET_VALUE;
        end
      end
    end
  end

  read_mux4 #(.DATAWIDTH(DATAWIDTH)) u_mux_a (
    .i_d0(r_mem[0]), .i_d1(r_mem[1]), .i_d2(r_mem[2]), .i_d3(r_mem[3]),
    .i_sel(i_read_address_a), .o_data(w_arr_a)
  );

  read_mux4 #(.DATAWIDTH(DATAWIDTH)) u_mux_b (
    .i_d0(r_mem[0]), .i_d1(r_mem[1]), .i_d2(r_mem[2]), .i_d3(r_mem[3]),
    .i_sel(i_read_address_b), .o_data(w_arr_b)
  );

`ifdef REGFILE_BYPASS_EN
  assign w_fwd_a = r_stage.tag.valid && (r_stage.tag.addr == i_read_address_a);
  assign w_fwd_b = r_stage.tag.valid && (r_stage.tag.addr == i_read_address_b);
`else
  assign w_fwd_a = 1'b0;
  assign w_fwd_b = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_a <= RESET_VALUE;
      r_rd_b <= RESET_VALUE;
    end else begin
      r_rd_a <= w_fwd_a ? r_stage.data : w_arr_a;
      r_rd_b <= w_fwd_b ? r_stage.data : w_arr_b;
    end
  end

  assign o_read_data_a = r_rd_a;
  assign o_read_data_b = r_rd_b;

endmodule
`default_nettype wire

// File: tb/tb_register_file4_staged.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_register_file4_staged : directed + randomized check vs. array model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_register_file4_staged;

  localparam logic [7:0] RV = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wv = 1'b0;
  logic       wr;
  logic [1:0] wa = 2'd0;
  logic [7:0] wd = 8'h00;
  logic       cr = 1'b0;
  logic       busy;
  logic [1:0] ra = 2'd0;
  logic [1:0] rb = 2'd0;
  logic [7:0] rda;
  logic [7:0] rdb;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain array, one pending write, sweep countdown.
  logic [7:0] m_mem [4];
  logic       m_pv;
  logic [1:0] m_pa;
  logic [7:0] m_pd;
  int         m_clr_left;
  logic [7:0] e_a;
  logic [7:0] e_b;

  always #5 clk = ~clk;

  register_file4_staged #(.DATAWIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_write_valid    (wv),
    .o_write_ready    (wr),
    .i_write_address  (wa),
    .i_write_data     (wd),
    .i_clear_request  (cr),
    .o_clear_busy     (busy),
    .i_read_address_a (ra),
    .o_read_data_a    (rda),
    .i_read_address_b (rb),
    .o_read_data_b    (rdb)
  );

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = RV;
    m_pv = 1'b0; m_pa = 2'd0; m_pd = 8'h00;
    m_clr_left = 0;
    e_a = RV; e_b = RV;
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge.
  task automatic tick();
    logic acc;
    @(posedge clk);
    acc = wv && (m_clr_left == 0) && !cr;
    e_a = m_mem[ra];
    e_b = m_mem[rb];
`ifdef REGFILE_BYPASS_EN
    if (m_pv && m_pa == ra) e_a = m_pd;
    if (m_pv && m_pa == rb) e_b = m_pd;
`endif
    if (m_pv) m_mem[m_pa] = m_pd;
    if (m_clr_left > 0) begin
      m_mem[4 - m_clr_left] = RV;
      m_clr_left--;
    end else if (cr) begin
      m_clr_left = 4;
    end
    m_pv = acc; m_pa = wa; m_pd = wd;
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (wr !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: ready=%b busy=%b required 1/0", wr, busy);
    end
    for (int i = 0; i < 4; i++) begin
      ra = 2'(i); rb = 2'(3 - i);
      tick();
      n_cmp++;
      if (rda !== 8'h00 || rdb !== 8'h00) begin
        n_err++; $display("FAIL reset_read[%0d]: a=%h b=%h required 00/00", i, rda, rdb);
      end
    end
  endtask

  task automatic test_write_read_latency();
    logic [7:0] exp1;
`ifdef REGFILE_BYPASS_EN
    exp1 = 8'hA5;
`else
    exp1 = 8'h00;
`endif
    wv = 1'b1; wa = 2'd2; wd = 8'hA5; ra = 2'd2;
    tick();
    wv = 1'b0;
    tick();
    n_cmp++;
    if (rda !== exp1) begin
      n_err++; $display("FAIL latency_e1: a=%h required %h", rda, exp1);
    end
    tick();
    n_cmp++;
    if (rda !== 8'hA5) begin
      n_err++; $display("FAIL latency_e2: a=%h required a5", rda);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      wv = 1'b1; wa = 2'(i); wd = 8'(8'h11 * (i + 1));
      #1;
      n_cmp++;
      if (wr !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready[%0d]: ready=%b required 1", i, wr);
      end
      tick();
    end
    wv = 1'b0;
    tick();
    ra = 2'd1; rb = 2'd3;
    tick();
    n_cmp++;
    if (rda !== 8'h22 || rdb !== 8'h44) begin
      n_err++; $display("FAIL b2b_read: a=%h b=%h required 22/44", rda, rdb);
    end
  endtask

  task automatic test_clear_collision();
    int nbusy;
    for (int i = 0; i < 4; i++) begin
      wv = 1'b1; wa = 2'(i); wd = 8'hFF;
      tick();
    end
    wv = 1'b0;
    tick();
    wv = 1'b1; wa = 2'd1; wd = 8'h5A; cr = 1'b1;
    #1;
    n_cmp++;
    if (wr !== 1'b0) begin
      n_err++; $display("FAIL collide_ready: ready=%b required 0", wr);
    end
    tick();
    wv = 1'b0; cr = 1'b0; ra = 2'd3;
    nbusy = (busy === 1'b1) ? 1 : 0;
    tick();
    n_cmp++;
    if (rda !== 8'hFF) begin
      n_err++; $display("FAIL midsweep_read: a=%h required ff", rda);
    end
    for (int k = 0; k < 8; k++) begin
      if (busy === 1'b1) nbusy++;
      tick();
    end
    n_cmp++;
    if (nbusy != 4) begin
      n_err++; $display("FAIL busy_cycles: observed %0d required 4", nbusy);
    end
    for (int i = 0; i < 4; i++) begin
      ra = 2'(i); rb = 2'(i);
      tick();
      n_cmp++;
      if (rda !== 8'h00 || rdb !== 8'h00) begin
        n_err++; $display("FAIL after_sweep[%0d]: a=%h b=%h required 00/00", i, rda, rdb);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 10) begin
      tick();
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s_timeout: busy=%b required 0", tag, busy);
    end
  endtask

  task automatic test_write_then_clear();
    wv = 1'b1; wa = 2'd1; wd = 8'h77;
    tick();
    wv = 1'b0; cr = 1'b1; ra = 2'd1;
    tick();
    cr = 1'b0;
    tick();
    n_cmp++;
    if (rda !== 8'h77) begin
      n_err++; $display("FAIL commit_before_sweep: a=%h required 77", rda);
    end
    wait_idle("wtc");
    for (int i = 0; i < 4; i++) begin
      ra = 2'(i); rb = 2'(3 - i);
      tick();
      n_cmp++;
      if (rda !== 8'h00 || rdb !== 8'h00) begin
        n_err++; $display("FAIL wtc_final[%0d]: a=%h b=%h required 00/00", i, rda, rdb);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    wv = 1'b1; wa = 2'd2; wd = 8'hC3;
    tick();
    wv = 1'b0;
    tick();
    ra = 2'd2; rb = 2'd2;
    tick();
    n_cmp++;
    if (rda !== 8'hC3) begin
      n_err++; $display("FAIL pre_reset_read: a=%h required c3", rda);
    end
    cr = 1'b1;
    tick();
    cr = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if (busy !== 1'b0 || rda !== 8'h00 || rdb !== 8'h00) begin
      n_err++; $display("FAIL reset_abort: busy=%b a=%h b=%h required 0/00/00", busy, rda, rdb);
    end
    rst_n = 1'b1;
    wv = 1'b1; wa = 2'd0; wd = 8'h3C;
    tick();
    wv = 1'b0; ra = 2'd0;
    tick();
    tick();
    n_cmp++;
    if (rda !== 8'h3C) begin
      n_err++; $display("FAIL post_reset_write: a=%h required 3c", rda);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wv = 1'($urandom_range(0, 1));
      wa = 2'($urandom_range(0, 3));
      wd = 8'($urandom);
      cr = ($urandom_range(0, 15) == 0);
      ra = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      #1;
      n_cmp++;
      if (wr !== ((m_clr_left == 0) && !cr)) begin
        n_err++; $display("FAIL rand_ready[%0d]: ready=%b required %b", n, wr, (m_clr_left == 0) && !cr);
      end
      tick();
      n_cmp++;
      if (rda !== e_a || rdb !== e_b) begin
        n_err++; $display("FAIL rand_read[%0d]: a=%h b=%h required %h/%h", n, rda, rdb, e_a, e_b);
      end
      n_cmp++;
      if (busy !== (m_clr_left > 0)) begin
        n_err++; $display("FAIL rand_busy[%0d]: busy=%b required %b", n, busy, m_clr_left > 0);
      end
    end
    wv = 1'b0; cr = 1'b0;
  endtask

  initial begin
    m_reset();
    #12;
    rst_n = 1'b1;
    #1;
    test_reset();
    test_write_read_latency();
    test_back_to_back();
    test_clear_collision();
    test_write_then_clear();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file4_staged.md
Name: register_file4_staged

Overview:
- 4-entry, DATAWIDTH-wide register file fed by the write-address decoder and read through 4:1 mux trees.
- Accepted writes pass through a one-entry staging register, then commit to the array.
- Two registered read ports.
- Includes a clear-sweep state machine that resets all entries, one per cycle.

Parameters:
DATAWIDTH, 8, width of each entry and of the data ports
RESET_VALUE, 0, value written to every entry at reset and by a clear sweep

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
write_valid  input  1  write request
write_ready  output  1  write can be accepted this cycle
write_address  input  2  entry to write
write_data  input  DATAWIDTH  data to write
clear_request  input  1  start a clear sweep (sampled only in IDLE)
clear_busy  output  1  clear sweep in progress
read_address_a  input  2  port A address
read_data_a  output  DATAWIDTH  port A data, registered
read_address_b  input  2  port B address
read_data_b  output  DATAWIDTH  port B data, registered

Behaviour:
- Reset: while rst_n is low, asynchronously set:
  - all 4 entries, read_data_a and read_data_b to RESET_VALUE
  - staging valid to 0
  - FSM to IDLE and sweep counter to 0
  - clear_busy to 0
- write_ready is combinational: (state==IDLE) && !clear_request.
- Write accept: a write is accepted at an edge where write_valid && write_ready. At that edge, staging captures {address, data} and staging valid is set to 1.
- Commit: at every edge where staging valid is 1, entry[staging address] takes the staged data.
  - Staging valid then takes the accept condition for that edge, so back-to-back writes stream one per cycle.
- Write-enable decode: one-hot over the 4 entries from staging address, gated by staging valid.
- Reads:
  - The address is sampled at an edge; read_data takes the array contents as they were before that edge's commit.
  - Latency is 1 cycle. Both ports are independent, and both may name the same entry.
- Write-to-read: a write accepted at edge E0 commits at E1. A read sampled at E2 or later returns the new value.
- FSM states:
  - IDLE: clear_request high at an edge → CLEAR with counter=0. A pending staged write still commits at that same edge, before the sweep.
  - CLEAR: each edge writes RESET_VALUE to entry[counter] and increments counter. The edge with counter==3 writes entry 3 and returns to IDLE; exactly 4 cycles in CLEAR.
- clear_busy = (state==CLEAR).
  - clear_request while in CLEAR is ignored; no re-trigger.
  - write_valid while in CLEAR is not accepted; write_ready is low.
- Simultaneous write_valid and clear_request in IDLE: clear wins and the write is not accepted. The writer holds its request until write_ready is seen high.
- Reads during CLEAR are legal and return each entry's current (partially cleared) contents.
- Reset mid-sweep or with staging valid aborts everything and applies the reset values above. The pending write is lost.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if staging valid is 1 and staging address equals a port's sampled read address at an edge, that port's read_data takes the staged data instead of the array value. Write-to-read then becomes: accept at E0, read sampled at E1 returns the new data.
- Undefined: no forwarding; a read sampled at E1 returns the old value.
- Staging is always empty in CLEAR, so the feature has no effect there.

Decomposition:
- Package register_file4_pkg holds:
  - ENTRIES=4 and ADDRBITS=2
  - the FSM state encoding (IDLE=1'b0, CLEAR=1'b1)
  - the staging-record layout {valid, address[1:0], data}
- Write-enable decode reuses the team's decoder2to4 module.
- One natural sub-module: read_mux4, a 2-level tree of basicmux instances replicated per data bit. It is instantiated once per read port.

Test Plan (DATAWIDTH=8, RESET_VALUE=0):
1. Release rst_n, then read address 0..3 on both ports → read_data_a = read_data_b = 8'h00; write_ready=1; clear_busy=0.
2. Write addr 2 data 8'hA5 at E0, read_address_a=2 sampled at E1 and at E2 → without REGFILE_BYPASS_EN: 8'h00 then 8'hA5. With the macro: 8'hA5 at both.
3. Back-to-back writes addr 0..3 = 8'h11, 8'h22, 8'h33, 8'h44 over 4 cycles, then read A=1 and B=3 → 8'h22 and 8'h44; write_ready high throughout.
4. Fill all entries with 8'hFF, raise clear_request together with write_valid (addr 1, 8'h5A) → write not accepted, write_ready=0.
   - clear_busy high for exactly 4 cycles.
   - Mid-sweep read of addr 3 returns 8'hFF; after the sweep all reads return 8'h00.
5. Write accepted at E0, assert clear_request at E1 → addr of the write holds the new data at E1, then is cleared by the sweep → final reads 8'h00.
6. Assert rst_n low during cycle 2 of the sweep → immediately clear_busy=0, read_data=8'h00; after release, a new write of 8'h3C to addr 0 reads back 8'h3C.
